// File: rtl/hp_tdm_scheduler_if.sv
// -----------------------------------------------------------------------------
// hp_tdm_scheduler_if
//
// Purpose:
//   Bundles the request side (per-channel sample valid/ready/data plus the
//   history clear) and the result side (valid/ready, data, channel tag) of the
//   time-division high-pass scheduler.
//
// Signals:
//   in_valid  [NUM_CH]         per-channel sample valid        (master -> slave)
//   in_data   [NUM_CH*DATA_W]  packed samples, ch k at [k*DATA_W +: DATA_W]
//   in_ready  [NUM_CH]         per-channel accept, one-hot or zero (slave -> master)
//   hist_clr                   synchronous clear of all histories (master -> slave)
//   out_valid                  result valid                    (slave -> master)
//   out_ready                  downstream accept               (master -> slave)
//   out_data  [DATA_W]         signed result x[n] - x[n-1]     (slave -> master)
//   out_ch    [CH_W]           channel tag of out_data         (slave -> master)
//
// Modports:
//   master : the environment (front-ends plus downstream consumer)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface hp_tdm_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     hist_clr;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        output hist_clr,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_ch
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        input  hist_clr,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_ch
    );
endinterface

// File: rtl/hp_tdm_scheduler.sv
// -----------------------------------------------------------------------------
// hp_tdm_scheduler
//
// Purpose:
//   Time-division scheduler letting NUM_CH sample sources share one
//   first-difference high-pass datapath (out = x[n] - x[n-1]). Requests are
//   arbitrated round-robin, one previous-sample history register is kept per
//   channel, at most one sample is issued per cycle and the result is returned
//   with its channel tag through a registered valid/ready output.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : hp_tdm_scheduler_if.slave (in_valid/in_data/in_ready, hist_clr,
//          out_valid/out_ready/out_data/out_ch)
//
// Parameters:
//   NUM_CH : number of requesting channels (2..16)
//   DATA_W : sample/result width, signed two's complement
//
// Configuration:
//   HP_SAT_EN : when defined, the difference is computed one bit wider and
//               saturated to the signed DATA_W range instead of wrapping.
//               Histories always store the raw input sample.
// -----------------------------------------------------------------------------
module hp_tdm_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hp_tdm_scheduler_if.slave    bus
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Difference helper: plain modulo-2^DATA_W wrap, or saturating when enabled
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] hp_diff(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] h
    );
`ifdef HP_SAT_EN
        logic [DATA_W:0] wide;
        wide = {x[DATA_W-1], x} - {h[DATA_W-1], h};
        // Top two bits disagree only when the true difference left the range.
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            if (wide[DATA_W]) begin
                hp_diff = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                hp_diff = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            hp_diff = wide[DATA_W-1:0];
        end
`else
        hp_diff = x - h;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [CH_W-1:0]     ptr_q;
    logic [CH_W-1:0]     ptr_d;
    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W-1:0]   out_data_d;
    logic [CH_W-1:0]     out_ch_q;
    logic [CH_W-1:0]     out_ch_d;
    logic [DATA_W-1:0]   hist_q [NUM_CH];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic                slot_free_s;
    logic                grant_valid_s;
    logic [CH_W-1:0]     grant_idx_s;
    logic                accept_s;
    logic [DATA_W-1:0]   sample_s;
    logic [DATA_W-1:0]   diff_s;
    logic [NUM_CH-1:0]   in_ready_s;

    // The output slot can take a new result when empty or being drained now.
    assign slot_free_s = (state_q == ST_IDLE) || bus.out_ready;

    // Round-robin search from the pointer, ascending with wrap.
    always_comb begin
        logic [CH_W:0] cand_v;
        logic          hit_v;
        grant_valid_s = 1'b0;
        grant_idx_s   = {CH_W{1'b0}};
        cand_v        = {(CH_W+1){1'b0}};
        hit_v         = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_v = {1'b0, ptr_q} + (CH_W+1)'(i);
            cand_v = (cand_v >= (CH_W+1)'(NUM_CH)) ? (cand_v - (CH_W+1)'(NUM_CH)) : cand_v;
            hit_v  = !grant_valid_s && bus.in_valid[cand_v[CH_W-1:0]];
            grant_idx_s   = hit_v ? cand_v[CH_W-1:0] : grant_idx_s;
            grant_valid_s = grant_valid_s | hit_v;
        end
    end

    // A grant only becomes an accept while the slot is free and no clear is
    // in progress; reset also masks in_ready so nothing is offered under reset.
    assign accept_s = grant_valid_s && slot_free_s && !bus.hist_clr && !rst;

    // Selected sample and its high-pass difference against the channel history.
    always_comb begin
        sample_s = bus.in_data[int'(grant_idx_s) * DATA_W +: DATA_W];
        diff_s   = hp_diff(sample_s, hist_q[grant_idx_s]);
    end

    // One-hot ready for the accepted channel, zero otherwise.
    always_comb begin
        if (accept_s) begin
            in_ready_s = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            in_ready_s = {NUM_CH{1'b0}};
        end
    end

    // FSM next state: IDLE <-> VALID, staying in VALID on back-to-back reloads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VALID: begin
                if (!bus.out_ready) begin
                    state_d = ST_VALID;
                end else if (accept_s) begin
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the output register and round-robin pointer.
    always_comb begin
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        if (accept_s) begin
            out_data_d = diff_s;
            out_ch_d   = grant_idx_s;
            ptr_d      = (grant_idx_s == (CH_W)'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                              : (grant_idx_s + {{(CH_W-1){1'b0}}, 1'b1});
        end else begin
            ptr_d      = ptr_q;
            out_data_d = out_data_q;
            out_ch_d   = out_ch_q;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential
    // -------------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= {CH_W{1'b0}};
            out_data_q <= {DATA_W{1'b0}};
            out_ch_q   <= {CH_W{1'b0}};
        end else begin
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

    // Per-channel history: cleared together, otherwise the accepted channel
    // stores its raw sample. Clear and accept are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hist_q[k] <= {DATA_W{1'b0}};
            end
        end else if (bus.hist_clr) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hist_q[k] <= {DATA_W{1'b0}};
            end
        end else if (accept_s) begin
            hist_q[grant_idx_s] <= sample_s;
        end else begin
            hist_q[grant_idx_s] <= hist_q[grant_idx_s];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_VALID);
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_hp_tdm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hp_tdm_scheduler
//
// Directed bench for hp_tdm_scheduler (NUM_CH=4, DATA_W=16). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled 1 unit after the edge
// and combinational in_ready is sampled 1 unit after the inputs change.
// -----------------------------------------------------------------------------
module tb_hp_tdm_scheduler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;

    logic clk;
    logic rst;

    int total;
    int bad;

    hp_tdm_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    hp_tdm_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected results of the six-grant round-robin run (channels 0,1,2,3,0,1).
    logic [15:0] rr_data [6];
    logic [15:0] rr_exp  [6];

    // Expected results of the boundary sequence on channel 2.
`ifdef HP_SAT_EN
    localparam logic [15:0] EXP_B0 = 16'h8000;
    localparam logic [15:0] EXP_B1 = 16'h7FFF;
    localparam logic [15:0] EXP_B2 = 16'h8000;
`else
    localparam logic [15:0] EXP_B0 = 16'h7FBA;
    localparam logic [15:0] EXP_B1 = 16'hFFFF;
    localparam logic [15:0] EXP_B2 = 16'h0001;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [15:0] v);
        bus.in_data[ch*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rr_data[0] = 16'd50;  rr_exp[0] = 16'h000A;
        rr_data[1] = 16'd60;  rr_exp[1] = 16'h003C;
        rr_data[2] = 16'd70;  rr_exp[2] = 16'h0046;
        rr_data[3] = 16'd80;  rr_exp[3] = 16'h004B;
        rr_data[4] = 16'd20;  rr_exp[4] = 16'hFFE2;
        rr_data[5] = 16'd100; rr_exp[5] = 16'h0028;

        // ---------------- reset state ----------------
        rst           = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = 64'h0;
        bus.hist_clr  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0000);
        chk("rst_out_data",  bus.out_data,       16'h0000);
        chk("rst_out_ch",    16'(bus.out_ch),    16'h0000);
        chk("rst_in_ready",  16'(bus.in_ready),  16'h0000);
        bus.in_valid = 4'b0000;
        rst          = 1'b0;
        tick();

        // ---------------- ch0: 100 then 40 ----------------
        bus.out_ready = 1'b1;
        set_data(0, 16'd100);
        bus.in_valid = 4'b0001;
        settle();
        chk("c0a_in_ready", 16'(bus.in_ready), 16'h0001);
        tick();
        chk("c0a_valid", 16'(bus.out_valid), 16'h0001);
        chk("c0a_data",  bus.out_data,       16'h0064);
        chk("c0a_ch",    16'(bus.out_ch),    16'h0000);
        set_data(0, 16'd40);
        settle();
        chk("c0b_in_ready", 16'(bus.in_ready), 16'h0001);
        tick();
        chk("c0b_valid", 16'(bus.out_valid), 16'h0001);
        chk("c0b_data",  bus.out_data,       16'hFFC4);
        chk("c0b_ch",    16'(bus.out_ch),    16'h0000);
        bus.in_valid = 4'b0000;
        tick();
        chk("drain_valid", 16'(bus.out_valid), 16'h0000);
        chk("drain_hold",  bus.out_data,       16'hFFC4);

        // ---------------- ch3 single sample moves pointer to 0 ----------------
        set_data(3, 16'd5);
        bus.in_valid = 4'b1000;
        settle();
        chk("c3_in_ready", 16'(bus.in_ready), 16'h0008);
        tick();
        bus.in_valid = 4'b0000;
        chk("c3_data", bus.out_data,    16'h0005);
        chk("c3_ch",   16'(bus.out_ch), 16'h0003);
        tick();

        // ---------------- all channels requesting: 0,1,2,3,0,1 ----------------
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            set_data(i % 4, rr_data[i]);
            settle();
            chk($sformatf("rr%0d_in_ready", i), 16'(bus.in_ready), 16'(1 << (i % 4)));
            tick();
            chk($sformatf("rr%0d_valid", i), 16'(bus.out_valid), 16'h0001);
            chk($sformatf("rr%0d_ch", i),    16'(bus.out_ch),    16'(i % 4));
            chk($sformatf("rr%0d_data", i),  bus.out_data,       rr_exp[i]);
        end

        // ---------------- stall with requests active ----------------
        bus.out_ready = 1'b0;
        settle();
        chk("stall_in_ready0", 16'(bus.in_ready), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_in_ready", i), 16'(bus.in_ready),  16'h0000);
            chk($sformatf("stall%0d_valid", i),    16'(bus.out_valid), 16'h0001);
            chk($sformatf("stall%0d_data", i),     bus.out_data,       16'h0028);
            chk($sformatf("stall%0d_ch", i),       16'(bus.out_ch),    16'h0001);
        end
        bus.out_ready = 1'b1;
        settle();
        chk("resume_in_ready", 16'(bus.in_ready), 16'h0004);
        tick();
        chk("resume_ch",   16'(bus.out_ch), 16'h0002);
        chk("resume_data", bus.out_data,    16'h0000);
        bus.in_valid = 4'b0000;
        tick();
        chk("resume_idle", 16'(bus.out_valid), 16'h0000);

        // ---------------- ch2 arithmetic boundaries ----------------
        bus.in_valid = 4'b0100;
        set_data(2, 16'h8000);
        settle();
        chk("b0_in_ready", 16'(bus.in_ready), 16'h0004);
        tick();
        chk("b0_data", bus.out_data, EXP_B0);
        set_data(2, 16'h7FFF);
        tick();
        chk("b1_data", bus.out_data, EXP_B1);
        set_data(2, 16'h8000);
        tick();
        chk("b2_data", bus.out_data, EXP_B2);
        chk("b2_ch",   16'(bus.out_ch), 16'h0002);
        bus.in_valid = 4'b0000;
        tick();

        // ---------------- ch1 history clear ----------------
        bus.in_valid = 4'b0010;
        set_data(1, 16'd500);
        tick();
        chk("h500_data", bus.out_data, 16'h0190);
        bus.in_valid = 4'b0000;
        tick();
        bus.hist_clr = 1'b1;
        bus.in_valid = 4'b0010;
        settle();
        chk("clr_in_ready", 16'(bus.in_ready), 16'h0000);
        tick();
        chk("clr_no_accept", 16'(bus.out_valid), 16'h0000);
        bus.hist_clr = 1'b0;
        set_data(1, 16'd7);
        settle();
        chk("post_clr_in_ready", 16'(bus.in_ready), 16'h0002);
        tick();
        chk("post_clr_data", bus.out_data,    16'h0007);
        chk("post_clr_ch",   16'(bus.out_ch), 16'h0001);

        // ---------------- reset while a result is pending ----------------
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        chk("pend_valid", 16'(bus.out_valid), 16'h0001);
        rst = 1'b1;
        settle();
        chk("async_rst_valid", 16'(bus.out_valid), 16'h0000);
        chk("async_rst_data",  bus.out_data,       16'h0000);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1010;
        settle();
        chk("rst_ptr_in_ready", 16'(bus.in_ready), 16'h0002);
        bus.in_valid = 4'b1000;
        set_data(3, 16'd9);
        settle();
        chk("rst_c3_in_ready", 16'(bus.in_ready), 16'h0008);
        tick();
        chk("rst_c3_valid", 16'(bus.out_valid), 16'h0001);
        chk("rst_c3_data",  bus.out_data,       16'h0009);
        chk("rst_c3_ch",    16'(bus.out_ch),    16'h0003);
        bus.in_valid = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hp_tdm_scheduler.md
Name: hp_tdm_scheduler

Overview:
- Time-division scheduler that lets NUM_CH sample sources share one first-difference high-pass datapath (out = x[n] - x[n-1]).
- Arbitrates per-channel valid/ready requests round-robin and keeps one history (previous-sample) register per channel.
- Issues at most one sample per cycle and returns a channel-tagged result through a valid/ready output port.
- Sits between the per-channel sample front-ends and downstream channel demux/processing.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_W, 16, sample and result width, signed two's complement.
- CH_W, $clog2(NUM_CH), width of the channel tag (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel sample-valid.
- in_data  input  NUM_CH*DATA_W  packed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept (one-hot or zero).
- hist_clr  input  1  synchronous clear of all channel histories.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  signed result x[n] - x[n-1] for out_ch.
- out_ch  output  CH_W  channel index of out_data.

Behaviour:
- Reset (rst=1, async):
  - out_valid=0, out_data=0, out_ch=0, in_ready=0.
  - All histories=0, round-robin pointer=0, FSM=IDLE.
- FSM states:
  - IDLE: output register empty, out_valid=0.
  - VALID: output register holds a result, out_valid=1.
- Slot free condition: (state==IDLE) or (state==VALID and out_ready=1).
- Arbitration, evaluated every cycle the slot is free and hist_clr=0:
  - Search in_valid starting at pointer p, ascending with wrap mod NUM_CH.
  - First asserted channel g is granted: in_ready[g]=1; all other in_ready=0.
  - in_ready is combinational from in_valid.
  - The slot is not free while state==VALID and out_ready=0, so in_ready=0 during a stall.
- Accept (in_valid[g] and in_ready[g]):
  - Next edge: out_data <= in_data[g] - hist[g], out_ch <= g, hist[g] <= in_data[g].
  - p <= (g+1) mod NUM_CH; state <= VALID.
  - Latency is 1 cycle from accept to out_valid.
- Back-to-back: in VALID with out_ready=1 and a grant present, the register reloads and state stays VALID, giving full throughput of 1 result/cycle.
- VALID with out_ready=1 and no request: state goes to IDLE and out_valid goes to 0. out_data and out_ch hold their last value.
- Stall: out_data and out_ch stay stable while out_valid=1 and out_ready=0.
- Arithmetic: DATA_W-bit two's-complement subtraction, result modulo 2^DATA_W (wrap-around).
- hist_clr=1:
  - Next edge: all histories <= 0.
  - in_ready=0 that cycle (no accept).
  - A pending output is unaffected and may still drain.
- No request while slot free: p unchanged.
- Reset mid-operation drops any pending result with no output handshake. Histories return to 0.

Optional Feature:
- Macro: HP_SAT_EN.
- Defined:
  - Difference computed at DATA_W+1 bits, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. For DATA_W=16 that is -32768..32767.
  - The history register still stores the raw input sample.
- Undefined: plain modulo-2^DATA_W wrap as above. No saturation logic is synthesised.

Test Plan:
- Reset, then ch0 sends 100, then 40, out_ready=1 -> out_data=100 (ch0), then -60 (ch0), each one cycle after accept.
- All four in_valid held high, out_ready=1 -> grant order 0,1,2,3,0,1, one per cycle, out_ch following the same sequence with 1-cycle lag.
- Result pending, out_ready=0 for 3 cycles with requests active -> in_ready=0, out_data/out_ch stable. Then out_ready=1 -> next grant resumes from pointer (no channel skipped).
- ch2 history 0x8000 (-32768), sample 0x7FFF:
  - without HP_SAT_EN -> out_data=0xFFFF (-1);
  - with HP_SAT_EN -> out_data=0x7FFF.
  - Sample 0x8000 after history 0x7FFF -> 0x0001 without HP_SAT_EN, 0x8000 with it.
- ch1 history 500, pulse hist_clr with ch1 valid -> no accept that cycle; next ch1 sample 7 -> out_data=7.
- rst asserted while out_valid=1 -> out_valid=0 immediately (async). After release, ch3 sample 9 -> out_data=9, and arbitration starts from ch0.
